reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor to the 8-bit register file.
- Register storage: generic width and register count, hardwired-zero r0, combinational dual read, single synchronous write, optional write-to-read bypass.
- Adds a per-register pending-write scoreboard (saturating counters) so the issue stage can detect RAW hazards and stall.
- Sits between the decode/issue stage and the ALU operand muxes.

Parameters:
DATA_W, 8, data width of each register and data port
ADDR_W, 5, register address width
NUM_REGS, 17, implemented registers 0..NUM_REGS-1; r0 is hardwired zero; must satisfy 2 <= NUM_REGS <= 2**ADDR_W
CNT_W, 2, pending-write counter width; counter saturates at 2**CNT_W-1
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
rw  in  1  write enable (writeback valid)
RD  in  ADDR_W  write address
RD_data  in  DATA_W  write data
RS  in  ADDR_W  read port A address
RT  in  ADDR_W  read port B address
RS_data  out  DATA_W  read port A data
RT_data  out  DATA_W  read port B data
issue_valid  in  1  issue stage is reserving a destination this cycle
issue_rd  in  ADDR_W  destination being reserved
issue_ready  out  1  reservation can be accepted this cycle
rs_busy  out  1  RS has an outstanding write
rt_busy  out  1  RT has an outstanding write

Behaviour:
- Address validity: valid(a) = (a != 0) && (a < NUM_REGS). Invalid addresses read 0, ignore writes, and never touch the scoreboard.
- Reset: at a posedge with rst=1, all regs <= 0 and all pend counters <= 0. rw and issue_valid in that cycle are ignored.
  - Next cycle, with rw=0: RS_data = RT_data = 0, rs_busy = rt_busy = 0, issue_ready = 1.
- Write: at posedge, if rw && valid(RD) && !rst, then reg[RD] <= RD_data. Visible on the read ports in the cycle after the edge.
- Read: combinational, zero-latency.
  - RS_data = valid(RS) ? reg[RS] : 0.
  - Bypass: if BYPASS=1 && rw && valid(RD) && RD==RS, then RS_data = RD_data in the same cycle.
  - RT is identical to RS.
  - Both ports may address the same register.
- Scoreboard: pend[a] is a CNT_W-bit counter, one per valid register.
  - inc = issue_valid && issue_ready && valid(issue_rd).
  - dec = rw && valid(RD) && pend[RD] != 0.
  - inc and dec on different regs: both apply.
  - inc and dec on the same reg: count unchanged.
  - dec on a count of 0 is a legacy unscoreboarded write: data is written, count stays 0, no error.
- issue_ready = !(valid(issue_rd) && pend[issue_rd] == max). It is 1 at max if the same cycle contains a dec to that reg. Invalid issue_rd is always ready and has no effect.
- rs_busy = valid(RS) && pend[RS] != 0, except:
  - It is 0 when BYPASS=1 and this cycle's writeback to RS takes pend from 1 to 0 with no same-cycle inc on RS.
  - rt_busy follows the same rule.
- Counters never wrap: saturation is enforced only through issue_ready. An inc while not ready is dropped.

Decomposition:
- Package rf_pkg holds:
  - default DATA_W/ADDR_W/NUM_REGS/CNT_W constants
  - typedefs reg_addr_t and reg_data_t
  - function rf_addr_valid(addr, num_regs)
- Sub-module rf_scoreboard: the counter array plus the inc/dec/ready/busy logic, parametrised by ADDR_W, NUM_REGS, CNT_W.
- reg_file_sb instantiates rf_scoreboard and owns the storage and read/bypass muxes.

Test Plan:
- Sweep write/read: for i in 0..31 and j in 0..255, write j to reg i, read on both RS and RT next cycle. Expect j for 1<=i<=16 and 0 otherwise.
- Bypass: rw=1, RD=5, RD_data=8'hA5, RS=RT=5 in the same cycle. Expect RS_data = RT_data = 8'hA5 before the edge with BYPASS=1, and the old value with BYPASS=0.
- Scoreboard saturation: issue r3 three times. Expect issue_ready=0 with issue_rd=3 and rs_busy=1 with RS=3. Then three writebacks to r3, after which rs_busy=0 and issue_ready=1.
- Simultaneous inc/dec: with pend[7]=1, issue r7 and write back r7 in the same cycle. Expect pend unchanged and rs_busy=1 the next cycle. A write to r0 with issue of r0 leaves r0 reading 0 and not busy.
- Mid-operation reset: load r1..r16 with 8'h11..8'h20 and pend[4]=2. Assert rst for one cycle together with rw=1, RD=4, RD_data=8'hFF. Expect all reads 0, all busy 0, and issue_ready=1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults, types and address-validity helper for the scoreboarded register file.
package rf_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 17;
  localparam int CNT_W_DEF    = 2;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // r0 is hardwired zero and addresses past the implemented range are dead.
  function automatic logic rf_addr_valid(input int unsigned addr, input int unsigned num_regs);
    return (addr != 0) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register saturating pending-write counters; ready/busy are combinational, counters update on posedge.
// Backpressure: issue_ready drops when the reserved destination is saturated, unless a writeback frees it this cycle.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_vld,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pend_q [1:NUM_REGS-1];
  logic [CNT_W-1:0] pend_d [1:NUM_REGS-1];

  logic             wb_ok, iss_ok, rs_ok, rt_ok;
  logic [CNT_W-1:0] wb_cnt, iss_cnt, rs_cnt, rt_cnt;
  logic             dec, inc;

  function automatic logic [CNT_W-1:0] pend_of(input logic [ADDR_W-1:0] a);
    pend_of = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) pend_of = pend_q[i];
    end
  endfunction

  always_comb begin
    wb_ok   = rf_addr_valid(32'(wb_rd), NUM_REGS);
    iss_ok  = rf_addr_valid(32'(issue_rd), NUM_REGS);
    rs_ok   = rf_addr_valid(32'(rs), NUM_REGS);
    rt_ok   = rf_addr_valid(32'(rt), NUM_REGS);
    wb_cnt  = pend_of(wb_rd);
    iss_cnt = pend_of(issue_rd);
    rs_cnt  = pend_of(rs);
    rt_cnt  = pend_of(rt);

    // A writeback to a zero count is an unscoreboarded legacy write and leaves the counter alone.
    dec         = wb_vld && wb_ok && (wb_cnt != '0);
    issue_ready = !(iss_ok && (iss_cnt == CNT_MAX)) || (dec && (wb_rd == issue_rd));
    inc         = issue_valid && issue_ready && iss_ok;

    // With forwarding, the last outstanding write landing this cycle already satisfies the reader.
    rs_busy = rs_ok && (rs_cnt != '0) &&
              !((BYPASS != 0) && dec && (wb_rd == rs) && (rs_cnt == CNT_ONE) &&
                !(inc && (issue_rd == rs)));
    rt_busy = rt_ok && (rt_cnt != '0) &&
              !((BYPASS != 0) && dec && (wb_rd == rt) && (rt_cnt == CNT_ONE) &&
                !(inc && (issue_rd == rt)));
  end

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      pend_d[i] = pend_q[i];
      if (inc && (issue_rd == ADDR_W'(i)) && !(dec && (wb_rd == ADDR_W'(i)))) begin
        pend_d[i] = pend_q[i] + CNT_ONE;
      end else if (dec && (wb_rd == ADDR_W'(i)) && !(inc && (issue_rd == ADDR_W'(i)))) begin
        pend_d[i] = pend_q[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rst) pend_q[i] <= '0;
      else     pend_q[i] <= pend_d[i];
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with hardwired r0, zero-latency dual read, one-cycle write and optional write-to-read forwarding.
// Backpressure: none on writeback; issue is throttled by the embedded scoreboard via issue_ready.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rw,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] RD_data,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic [DATA_W-1:0] RS_data,
  output logic [DATA_W-1:0] RT_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];

  logic wr_ok, rs_ok, rt_ok;

  function automatic logic [DATA_W-1:0] reg_of(input logic [ADDR_W-1:0] a);
    reg_of = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) reg_of = regs_q[i];
    end
  endfunction

  always_comb begin
    wr_ok = rf_addr_valid(32'(RD), NUM_REGS);
    rs_ok = rf_addr_valid(32'(RS), NUM_REGS);
    rt_ok = rf_addr_valid(32'(RT), NUM_REGS);
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (rw && wr_ok && (RD == ADDR_W'(i))) regs_d[i] = RD_data;
    end
  end

  always_comb begin
    RS_data = rs_ok ? reg_of(RS) : '0;
    RT_data = rt_ok ? reg_of(RT) : '0;
    if ((BYPASS != 0) && rw && wr_ok && (RD == RS)) RS_data = RD_data;
    if ((BYPASS != 0) && rw && wr_ok && (RD == RT)) RT_data = RD_data;
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rst) regs_q[i] <= '0;
      else     regs_q[i] <= regs_d[i];
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS),
    .CNT_W   (CNT_W),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wb_vld     (rw),
    .wb_rd      (RD),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .rs         (RS),
    .rt         (RT),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: forwarding and non-forwarding instances share stimulus and are checked against an array model.
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int NR = 17;
  localparam int CMAX = 3;

  logic      clk = 1'b0;
  logic      rst, rw, issue_valid;
  reg_addr_t RD, RS, RT, issue_rd;
  reg_data_t RD_data;
  reg_data_t rs_data1, rt_data1, rs_data0, rt_data0;
  logic      ready1, rsb1, rtb1, ready0, rsb0, rtb0;

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .rw(rw), .RD(RD), .RD_data(RD_data), .RS(RS), .RT(RT),
    .RS_data(rs_data1), .RT_data(rt_data1), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(ready1), .rs_busy(rsb1), .rt_busy(rtb1));

  reg_file_sb #(.BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .rw(rw), .RD(RD), .RD_data(RD_data), .RS(RS), .RT(RT),
    .RS_data(rs_data0), .RT_data(rt_data0), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(ready0), .rs_busy(rsb0), .rt_busy(rtb0));

  int total = 0;
  int bad   = 0;

  int m_reg  [32];
  int m_pend [32];

  logic [31:0] ob_rs1, ob_rt1, ob_rs0, ob_rt0, ob_ready, ob_rsb1, ob_rtb1, ob_rsb0;

  function automatic bit v(input int a);
    return (a != 0) && (a < NR);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic r, input logic w, input int rd, input int d, input int rs,
                      input int rt, input logic iv, input int ird);
    bit dec, inc, rdy;
    int e_rs1, e_rt1, e_rs0, e_rt0;
    bit e_rsb1, e_rtb1, e_rsb0, e_rtb0;
    rst = r; rw = w; RD = rd[4:0]; RD_data = d[7:0]; RS = rs[4:0]; RT = rt[4:0];
    issue_valid = iv; issue_rd = ird[4:0];
    dec = w && v(rd) && (m_pend[rd] != 0);
    rdy = !v(ird) || (m_pend[ird] < CMAX) || (dec && rd == ird);
    inc = iv && rdy && v(ird);
    e_rs0 = v(rs) ? m_reg[rs] : 0;
    e_rt0 = v(rt) ? m_reg[rt] : 0;
    e_rs1 = (w && v(rd) && rd == rs && v(rs)) ? (d & 8'hFF) : e_rs0;
    e_rt1 = (w && v(rd) && rd == rt && v(rt)) ? (d & 8'hFF) : e_rt0;
    e_rsb0 = v(rs) && m_pend[rs] != 0;
    e_rtb0 = v(rt) && m_pend[rt] != 0;
    e_rsb1 = e_rsb0 && !(dec && rd == rs && m_pend[rs] == 1 && !(inc && ird == rs));
    e_rtb1 = e_rtb0 && !(dec && rd == rt && m_pend[rt] == 1 && !(inc && ird == rt));
    @(negedge clk);
    ob_rs1 = 32'(rs_data1); ob_rt1 = 32'(rt_data1); ob_rs0 = 32'(rs_data0); ob_rt0 = 32'(rt_data0);
    ob_ready = 32'(ready1); ob_rsb1 = 32'(rsb1); ob_rtb1 = 32'(rtb1); ob_rsb0 = 32'(rsb0);
    if (!r) begin
      chk("rs_data_byp", ob_rs1, e_rs1);
      chk("rt_data_byp", ob_rt1, e_rt1);
      chk("rs_data_nobyp", ob_rs0, e_rs0);
      chk("rt_data_nobyp", ob_rt0, e_rt0);
      chk("issue_ready_byp", ob_ready, 32'(rdy));
      chk("issue_ready_nobyp", 32'(ready0), 32'(rdy));
      chk("rs_busy_byp", ob_rsb1, 32'(e_rsb1));
      chk("rt_busy_byp", ob_rtb1, 32'(e_rtb1));
      chk("rs_busy_nobyp", ob_rsb0, 32'(e_rsb0));
      chk("rt_busy_nobyp", 32'(rtb0), 32'(e_rtb0));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
    end else begin
      if (w && v(rd)) m_reg[rd] = d & 8'hFF;
      if (inc) m_pend[ird] = m_pend[ird] + 1;
      if (dec) m_pend[rd] = m_pend[rd] - 1;
    end
    #1;
  endtask

  initial begin
    int a, b;
    rst = 1'b1; rw = 1'b0; RD = '0; RD_data = '0; RS = '0; RT = '0;
    issue_valid = 1'b0; issue_rd = '0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16, 0, 1);
    chk("reset_rs", ob_rs1, 0); chk("reset_rt", ob_rt1, 0);
    chk("reset_busy", ob_rsb1 | ob_rtb1, 0); chk("reset_ready", ob_ready, 1);

    // write/read sweep over every address and data value
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 256; j++) begin
        step(0, 1, i, j, i, i, 0, 0);
        step(0, 0, 0, 0, i, i, 0, 0);
        if (j == 255) begin
          chk("sweep_rs", ob_rs1, v(i) ? 32'd255 : 32'd0);
          chk("sweep_rt", ob_rt0, v(i) ? 32'd255 : 32'd0);
        end
      end
    end

    // forwarding vs stored value
    step(0, 1, 5, 'h33, 0, 0, 0, 0);
    step(0, 1, 5, 'hA5, 5, 5, 0, 0);
    chk("bypass_rs", ob_rs1, 'hA5); chk("bypass_rt", ob_rt1, 'hA5);
    chk("nobypass_rs", ob_rs0, 'h33); chk("nobypass_rt", ob_rt0, 'h33);

    // saturation on r3
    repeat (3) step(0, 0, 0, 0, 3, 3, 1, 3);
    step(0, 0, 0, 0, 3, 3, 1, 3);
    chk("sat_ready", ob_ready, 0); chk("sat_busy", ob_rsb1, 1);
    step(0, 1, 3, 'h01, 3, 3, 1, 3);
    chk("sat_ready_dec", ob_ready, 1);
    step(0, 1, 3, 'h02, 3, 3, 0, 3);
    step(0, 1, 3, 'h03, 3, 3, 0, 3);
    step(0, 1, 3, 'h04, 3, 3, 0, 3);
    chk("last_wb_busy_byp", ob_rsb1, 0); chk("last_wb_busy_nobyp", ob_rsb0, 1);
    step(0, 0, 0, 0, 3, 3, 0, 3);
    chk("drain_busy", ob_rsb1, 0); chk("drain_ready", ob_ready, 1);

    // simultaneous inc/dec on r7, and r0 immunity
    step(0, 0, 0, 0, 0, 0, 1, 7);
    step(0, 1, 7, 'h77, 7, 7, 1, 7);
    step(0, 0, 0, 0, 7, 7, 0, 0);
    chk("incdec_busy", ob_rsb1, 1);
    step(0, 1, 0, 'h99, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_data", ob_rs1, 0); chk("r0_busy", ob_rsb1, 0);
    step(0, 1, 7, 'h78, 7, 7, 0, 0);

    // mid-operation reset
    for (int i = 1; i < NR; i++) step(0, 1, i, 'h10 + i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 4, 4, 1, 4);
    step(0, 0, 0, 0, 4, 4, 1, 4);
    chk("pre_rst_busy", ob_rsb1, 1);
    step(1, 1, 4, 'hFF, 4, 4, 1, 4);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, i, 31 - i, 0, i);
      chk("post_rst_rs", ob_rs1, 0); chk("post_rst_rt", ob_rt1, 0);
      chk("post_rst_busy", ob_rsb1 | ob_rtb1, 0); chk("post_rst_ready", ob_ready, 1);
    end

    // random traffic concentrated on a few registers to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 255)),
           int'($urandom_range(0, 6)), int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
